// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store executor.
// Width codes match the decoder's memory-control bundle.
package mem_access_unit_pkg;

   localparam logic [1:0] WIDTH_BYTE    = 2'b00;
   localparam logic [1:0] WIDTH_HALF    = 2'b01;
   localparam logic [1:0] WIDTH_ILLEGAL = 2'b10;
   localparam logic [1:0] WIDTH_WORD    = 2'b11;

   localparam logic SIGN_SIGNED   = 1'b0;
   localparam logic SIGN_UNSIGNED = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
      logic fault;
      case (width)
         WIDTH_BYTE:    fault = 1'b0;
         WIDTH_HALF:    fault = lane[0];
         WIDTH_WORD:    fault = (lane != 2'b00);
         default:       fault = 1'b1;
      endcase
      return fault;
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] lane);
      logic [3:0] be;
      case (width)
         WIDTH_BYTE: be = 4'b0001 << lane;
         WIDTH_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] replicate_store(input logic [1:0] width, input logic [31:0] wdata);
      logic [31:0] data;
      case (width)
         WIDTH_BYTE: data = {4{wdata[7:0]}};
         WIDTH_HALF: data = {2{wdata[15:0]}};
         default:    data = wdata;
      endcase
      return data;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load lane select plus sign/zero extension.
// Kept standalone so the forwarding path can reuse it.
module mem_load_align
   import mem_access_unit_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] i_rdata,
   input  logic [1:0]         i_lane,
   input  logic [1:0]         i_width,
   input  logic               i_sign_flag,
   output logic [NB_DATA-1:0] o_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        extend;

   always_comb begin
      byte_sel = i_rdata[{i_lane, 3'b000} +: 8];
      half_sel = i_rdata[{i_lane[1], 4'b0000} +: 16];
      extend   = (i_sign_flag == SIGN_SIGNED);
      case (i_width)
         WIDTH_BYTE: o_data = {{(NB_DATA-8){extend & byte_sel[7]}}, byte_sel};
         WIDTH_HALF: o_data = {{(NB_DATA-16){extend & half_sel[15]}}, half_sel};
         default:    o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store executor: req/ack data-memory port, byte enables,
// lane-replicated store data, extended load data and pipeline stall.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 32
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic               i_mem_read,
   input  logic               i_mem_write,
   input  logic [1:0]         i_width,
   input  logic               i_sign_flag,
   input  logic [NB_ADDR-1:0] i_addr,
   input  logic [NB_DATA-1:0] i_wdata,
   output logic               o_stall,
   output logic               o_done,
   output logic [NB_DATA-1:0] o_rdata,
   output logic               o_misaligned,
   output logic               o_mem_req,
   output logic               o_mem_we,
   output logic [NB_ADDR-3:0] o_mem_addr,
   output logic [3:0]         o_mem_be,
   output logic [NB_DATA-1:0] o_mem_wdata,
   input  logic               i_mem_ack,
   input  logic [NB_DATA-1:0] i_mem_rdata
);

   state_t state, state_next;

   logic               start;
   logic               fault;
   logic [NB_ADDR-3:0] addr_q;
   logic [1:0]         lane_q;
   logic [3:0]         be_q;
   logic [NB_DATA-1:0] wdata_q;
   logic [1:0]         width_q;
   logic               sign_q;
   logic               we_q;
   logic               fault_q;
   logic [NB_DATA-1:0] rdata_q;
   logic [NB_DATA-1:0] load_data;

   mem_load_align #(
      .NB_DATA (NB_DATA)
   ) u_load_align (
      .i_rdata     (i_mem_rdata),
      .i_lane      (lane_q),
      .i_width     (width_q),
      .i_sign_flag (sign_q),
      .o_data      (load_data)
   );

   always_ff @(posedge clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Everything is captured on accept so the memory port stays stable
   // while the upstream instruction is frozen but may still be changing.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         addr_q  <= '0;
         lane_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         width_q <= '0;
         sign_q  <= '0;
         we_q    <= '0;
         fault_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= i_addr[NB_ADDR-1:2];
                  lane_q  <= i_addr[1:0];
                  be_q    <= byte_enables(i_width, i_addr[1:0]);
                  wdata_q <= replicate_store(i_width, i_wdata);
                  width_q <= i_width;
                  sign_q  <= i_sign_flag;
                  we_q    <= i_mem_write;
                  fault_q <= fault;
                  rdata_q <= '0;
               end
            end
            ST_REQ: begin
               if (i_mem_ack) rdata_q <= we_q ? '0 : load_data;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      start        = i_valid & (i_mem_read | i_mem_write);
      fault        = is_misaligned(i_width, i_addr[1:0]);
      state_next   = state;
      o_stall      = 1'b0;
      o_done       = 1'b0;
      o_rdata      = '0;
      o_misaligned = 1'b0;
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_mem_addr   = '0;
      o_mem_be     = '0;
      o_mem_wdata  = '0;
      case (state)
         ST_IDLE: begin
            o_stall = start;
            if (start) state_next = fault ? ST_DONE : ST_REQ;
         end
         ST_REQ: begin
            o_stall     = 1'b1;
            o_mem_req   = 1'b1;
            o_mem_we    = we_q;
            o_mem_addr  = addr_q;
            o_mem_be    = be_q;
            o_mem_wdata = wdata_q;
            if (i_mem_ack) state_next = ST_DONE;
         end
         ST_DONE: begin
            o_done       = 1'b1;
            o_misaligned = fault_q;
            o_rdata      = rdata_q;
            state_next   = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a result scoreboard and
// an independent reference model of alignment, enables and extension.
module tb_mem_access_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst, i_valid, i_mem_read, i_mem_write, i_sign_flag, i_mem_ack;
   logic [1:0]  i_width;
   logic [31:0] i_addr, i_wdata, i_mem_rdata;
   logic        o_stall, o_done, o_misaligned, o_mem_req, o_mem_we;
   logic [31:0] o_rdata, o_mem_wdata;
   logic [29:0] o_mem_addr;
   logic [3:0]  o_mem_be;

   int   checks   = 0;
   int   failures = 0;
   int   hs_cnt   = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_access_unit #(
      .NB_DATA (32),
      .NB_ADDR (32)
   ) dut (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_mem_read   (i_mem_read),
      .i_mem_write  (i_mem_write),
      .i_width      (i_width),
      .i_sign_flag  (i_sign_flag),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_stall      (o_stall),
      .o_done       (o_done),
      .o_rdata      (o_rdata),
      .o_misaligned (o_misaligned),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_be     (o_mem_be),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_ack    (i_mem_ack),
      .i_mem_rdata  (i_mem_rdata)
   );

   always @(posedge clk) begin
      if (o_mem_req && i_mem_ack) hs_cnt++;
      if (o_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic model_mis(input logic [1:0] w, input logic [31:0] a);
      if (w == 2'b10) return 1'b1;
      if (w == 2'b01) return a[0];
      if (w == 2'b11) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] w, input logic s,
                                              input logic [31:0] a, input logic [31:0] md);
      int          amt;
      logic [31:0] sh;
      amt = (w == 2'b01) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
      sh  = md >> amt;
      if (w == 2'b00) return s ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      if (w == 2'b01) return s ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      return md;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
      if (w == 2'b00) return 4'(1 << a[1:0]);
      if (w == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] wd);
      if (w == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      if (w == 2'b01) return {wd[15:0], wd[15:0]};
      return wd;
   endfunction

   task automatic check_all_zero(input string name);
      check({name, "_stall"}, 32'(o_stall), 32'h0);
      check({name, "_done"}, 32'(o_done), 32'h0);
      check({name, "_rdata"}, o_rdata, 32'h0);
      check({name, "_mis"}, 32'(o_misaligned), 32'h0);
      check({name, "_req"}, 32'(o_mem_req), 32'h0);
      check({name, "_we"}, 32'(o_mem_we), 32'h0);
      check({name, "_addr"}, 32'(o_mem_addr), 32'h0);
      check({name, "_be"}, 32'(o_mem_be), 32'h0);
      check({name, "_wdata"}, o_mem_wdata, 32'h0);
   endtask

   // One access: accept, optional ack delay, completion, one idle cycle.
   task automatic run_access(input string name, input logic rd, input logic wr,
                             input logic [1:0] w, input logic s, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] md,
                             input int delay, input bit hold);
      exp_t e;
      logic mis;
      int   stall_n = 0, waits = 0, done_cyc = -1, hs0, dn0;
      bit   req_seen = 0;
      mis = model_mis(w, a);
      @(posedge clk); #1;
      i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_width = w;
      i_sign_flag = s; i_addr = a; i_wdata = wd;
      hs0 = hs_cnt; dn0 = done_cnt;
      e.rdata = (mis || wr) ? 32'h0 : model_load(w, s, a, md);
      e.mis   = mis;
      sb.push_back(e);
      for (int k = 0; k < 20 && done_cyc < 0; k++) begin
         @(negedge clk);
         if (o_stall) stall_n++;
         if (o_mem_req) begin
            req_seen = 1;
            check({name, "_addr"}, 32'(o_mem_addr), 32'(a[31:2]));
            check({name, "_be"}, 32'(o_mem_be), 32'(model_be(w, a)));
            check({name, "_we"}, 32'(o_mem_we), 32'(wr));
            if (wr) check({name, "_wdata"}, o_mem_wdata, model_wdata(w, wd));
            if (waits == delay) begin
               i_mem_ack = 1'b1; i_mem_rdata = md;
            end else waits++;
         end
         if (o_done) begin
            done_cyc = k;
            if (sb.size() == 0) check({name, "_sb_empty"}, 32'h1, 32'h0);
            else begin
               e = sb.pop_front();
               check({name, "_rdata"}, o_rdata, e.rdata);
               check({name, "_mis"}, 32'(o_misaligned), 32'(e.mis));
            end
         end
         @(posedge clk); #1;
         i_mem_ack = 1'b0;
         if (!hold || done_cyc >= 0) i_valid = 1'b0;
      end
      if (done_cyc < 0 && sb.size() != 0) void'(sb.pop_front());
      check({name, "_done_cycle"}, 32'(done_cyc), mis ? 32'd1 : 32'(2 + delay));
      check({name, "_stall_cycles"}, 32'(stall_n), mis ? 32'd1 : 32'(2 + delay));
      check({name, "_req_seen"}, 32'(req_seen), 32'(!mis));
      @(negedge clk);
      check({name, "_idle_stall"}, 32'(o_stall), 32'h0);
      check({name, "_idle_req"}, 32'(o_mem_req), 32'h0);
      check({name, "_handshakes"}, 32'(hs_cnt - hs0), mis ? 32'd0 : 32'd1);
      check({name, "_done_pulses"}, 32'(done_cnt - dn0), 32'd1);
   endtask

   initial begin
      int hs0, dn0;
      i_rst = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      i_width = 2'b00; i_sign_flag = 1'b0; i_addr = '0; i_wdata = '0;
      i_mem_ack = 1'b0; i_mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      i_rst = 1'b0;

      run_access("lb",  1, 0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0);
      run_access("lbu", 1, 0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0);
      run_access("sh",  0, 1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 0, 0);
      run_access("lw_wait", 1, 0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3, 0);
      run_access("lw_mis",  1, 0, 2'b11, 1'b0, 32'h0000_0041, 32'h0, 32'h1111_1111, 0, 0);
      run_access("lh",  1, 0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 0);
      run_access("lhu", 1, 0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'h80FF_9234, 1, 0);
      run_access("lb_pos", 1, 0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, 32'h0000_7F00, 0, 0);
      run_access("sb",  0, 1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_5678, 32'h0, 0, 0);
      run_access("sw",  0, 1, 2'b11, 1'b0, 32'h0000_0010, 32'hA5A5_0F0F, 32'h0, 2, 0);
      run_access("lw_s1", 1, 0, 2'b11, 1'b1, 32'h0000_0020, 32'h0, 32'h8000_0001, 0, 0);
      run_access("lh_mis", 1, 0, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 32'h0, 0, 0);
      run_access("w10_st", 0, 1, 2'b10, 1'b0, 32'h0000_0008, 32'h1, 32'h0, 0, 0);
      run_access("rdwr",  1, 1, 2'b11, 1'b0, 32'h0000_0030, 32'h0BAD_CAFE, 32'hFFFF_FFFF, 0, 0);
      run_access("hold",  1, 0, 2'b11, 1'b0, 32'h0000_0060, 32'h0, 32'hCAFE_F00D, 0, 1);

      // Reset while a request is outstanding; the ack that follows must be dropped.
      @(posedge clk); #1;
      i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_width = 2'b11;
      i_sign_flag = 1'b0; i_addr = 32'h0000_0080;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      check("rst_req_active", 32'(o_mem_req), 32'h1);
      hs0 = hs_cnt; dn0 = done_cnt;
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
      @(negedge clk);
      check_all_zero("rst_mid");
      @(posedge clk); #1;
      i_mem_ack = 1'b0;
      @(negedge clk);
      check("rst_no_done", 32'(o_done), 32'h0);
      check("rst_no_handshake", 32'(hs_cnt - hs0), 32'h0);
      check("rst_no_done_pulse", 32'(done_cnt - dn0), 32'h0);

      run_access("post_rst_lb", 1, 0, 2'b00, 1'b1, 32'h0000_0002, 32'h0, 32'h00C3_0000, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store executor for the MIPS pipeline. Consumes the memory-control bundle produced by the decoder: read, write, width and sign flag. Drives a request/acknowledge data-memory port with byte enables and lane-aligned store data. Returns sign- or zero-extended load data and stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- NB_DATA, 32, data width (fixed 4 byte lanes)
- NB_ADDR, 32, byte-address width

Ports:
- clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  MEM-stage instruction valid
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_width  in  2  11 = word, 01 = half, 00 = byte, 10 = illegal
- i_sign_flag  in  1  0 = signed, 1 = unsigned (loads only)
- i_addr  in  NB_ADDR  byte address from the ALU
- i_wdata  in  NB_DATA  store data (rt)
- o_stall  out  1  freeze upstream stages
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  NB_DATA  extended load data, valid with o_done
- o_misaligned  out  1  alignment fault, pulses with o_done
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write
- o_mem_addr  out  NB_ADDR-2  word address, i_addr[NB_ADDR-1:2]
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  NB_DATA  lane-replicated store data
- i_mem_ack  in  1  request accepted; read data valid in the same cycle
- i_mem_rdata  in  NB_DATA  read data

## Operation
- FSM states:
  - IDLE: start = i_valid & (i_mem_read | i_mem_write).
    - On start with a misaligned access: latch the fault and go to DONE. No memory request is issued.
    - On start otherwise: register address, be, wdata, width, sign and we, then go to REQ.
  - REQ: hold o_mem_req and all o_mem_* stable until i_mem_ack. On ack, capture the extended rdata and go to DONE.
  - DONE: one cycle, then IDLE. o_done=1 and inputs are ignored, since the same instruction is still present.
- Misaligned access:
  - half with i_addr[0]=1
  - word with i_addr[1:0]≠0
  - width 10 with either read or write
- Read and write both set: the store is performed and the read is ignored.
- Byte enables, lane = i_addr[1:0]:
  - byte: 1<<lane
  - half: i_addr[1] ? 1100 : 0011
  - word: 1111
- Store data: byte replicated ×4; half replicated ×2; word passed through.
- Load extract:
  - byte: rdata[8·lane +: 8]
  - half: rdata[16·i_addr[1] +: 16]
  - extend with bit 7 or bit 15 when sign_flag=0; zero-extend when sign_flag=1
  - word returned unchanged regardless of sign_flag
- o_rdata is 0 for stores and faults.
- o_mem_we is 1 only in REQ for stores.
- i_mem_ack outside REQ is ignored.

## Timing
- o_stall = (IDLE & start) | REQ. It is combinational from i_valid and the state, and is low in DONE.
- Minimum latency: accept at cycle 0, o_mem_req at cycle 1, ack at cycle 1, o_done/o_rdata at cycle 2. o_stall is high in cycles 0–1.
- Each extra cycle without ack adds one stall cycle. There is no timeout.
- Fault path: accept at cycle 0, o_done and o_misaligned at cycle 1, o_mem_req never asserted.
- Reset, including mid-REQ: the next state is IDLE.
  - All outputs read 0 the cycle after reset is sampled: o_stall, o_done, o_rdata, o_misaligned, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata.
  - A late ack is dropped.
- Back-to-back accesses: the earliest second accept is the cycle after DONE.

## Structure
- Shared package holds:
  - width encodings WIDTH_BYTE=00, WIDTH_HALF=01, WIDTH_WORD=11
  - sign-flag constants
  - FSM state encoding for IDLE/REQ/DONE
- Sub-module mem_load_align: combinational lane select plus extension (inputs: rdata, addr[1:0], width, sign). It is reusable by the forwarding path.

## Test plan
- LB at addr 0x103, rdata 0x80FF_1234, sign=0 → o_rdata 0xFFFF_FF80 at cycle 2 with ack at cycle 1; LBU → 0x0000_0080.
- SH at addr 0x202, wdata 0x0000_BEEF → o_mem_be 1100, o_mem_wdata 0xBEEF_BEEF, o_mem_addr 0x80, o_mem_we=1.
- LW at addr 0x40 with ack withheld 3 cycles → o_mem_req and address stable throughout, o_stall high 5 cycles, o_done once.
- LW at addr 0x41 → o_misaligned and o_done at cycle 1, o_mem_req never asserted, o_rdata 0.
- Reset asserted during REQ, ack arriving the next cycle → all outputs 0, state IDLE, no o_done.
- i_valid held through DONE → exactly one memory request issued.
